mips_test: RTL and testbench
============================

// Module: mips_test
// PURPOSE
//  Single-cycle 32-bit MIPS CPU core with its own instruction memory, data memory and register file.
//  Executes one instruction per clock: ADD, SUB, AND, OR, SLT, LW, SW, BEQ, J.
//  Top of the CPU hierarchy; benches preload memories and registers through hierarchical paths.
// PARAMETERS
//  IMEM_BYTES  128  instruction memory size in bytes (byte array, little-endian words)
//  DMEM_BYTES  128  data memory size in bytes (byte array, little-endian words)
// PORTS
//  clk  input  1  single clock; all state updates on rising edge
//  rst  input  1  asynchronous, active-high reset
// BEHAVIOUR
//  - Reset: pc <= 32'h0 immediately on rst high and held while rst high.
//    Register file and both memories are NOT cleared, so bench preloads survive.
//    No register or data-memory write occurs while rst is high.
//  - Fetch: word at pc = {mem[pc+3],mem[pc+2],mem[pc+1],mem[pc]}, combinational.
//    All memory addresses are taken modulo memory size (wrap-around).
//  - Decode fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0] sign-extended.
//  - R-type (opcode 0): rd <= rs OP rt.
//    funct 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT (signed, result 1/0).
//    Arithmetic is 32-bit wrap, no overflow trap. Other funct values: no write.
//  - LW (35): rt <= dmem word at rs+sext(imm). SW (43): dmem word at rs+sext(imm) <= rt, bytes little-endian.
//  - BEQ (4): if rs==rt, next pc = pc+4+(sext(imm)<<2), else pc+4. No delay slot.
//  - J (2): next pc = {pc_plus4[31:28], instr[25:0], 2'b00}.
//  - Any other opcode: NOP, pc+4, no writes.
//  - Register $0 reads 0 always; writes to $0 are discarded.
//  - Register write and dmem write commit on the same rising edge that loads the new pc.
//  - Reads are combinational, so a read of the register being written returns the old value this cycle.
//  - rfile_wd = LW ? dmem read data : ALU result.
//  - Unaligned addresses: word formed from the 4 consecutive bytes, no exception.
//  - Required visible nets at top level:
//    pc[31:0], opcode[5:0], funct[5:0], rfile_wd[31:0].
//  - Required instance names and arrays:
//    InstrMem.mem_array[0:IMEM_BYTES-1][7:0], DatMem.mem_array[0:DMEM_BYTES-1][7:0],
//    RegFile.file_array[0:31][31:0].
// STRUCTURE
//  - Shared package mips_pkg holds:
//    - opcode constants: OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2
//    - funct constants: F_ADD=32, F_SUB=34, F_AND=36, F_OR=37, F_SLT=42
//    - ALU op enum.
//  - Sub-modules:
//    - instr_mem (InstrMem): async read
//    - data_mem (DatMem): async read, sync write
//    - reg_file (RegFile): 2 read ports, 1 sync write port
//    - alu: decoded control
//  - Control decode and pc logic stay in mips_test.
// TESTING
//  - Reset: hold rst 10ns with preloaded regs -> pc==0 during rst; reg/mem contents unchanged after release.
//  - R-type: $1=5, $2=3; ADD $3,$1,$2 -> rfile_wd=8, $3=8. SUB -> 2. AND -> 1. OR -> 7. SLT $4,$2,$1 -> 1.
//  - Memory: dmem[0..3]=78,56,34,12; LW $5,0($0) -> $5=32'h12345678.
//    Then SW $5,4($0) -> dmem[4..7]=78,56,34,12.
//  - BEQ: $1==$2 with imm=2 at pc=8 -> next pc=20; unequal -> next pc=12.
//    J target 26'h10 at pc=0x1C -> next pc=0x40.
//  - $0 / wrap: ADD $0,$1,$1 -> $0 stays 0; LW at address DMEM_BYTES -> reads bytes 0..3.
//  - Async reset mid-run: assert rst between edges at pc=0x24 -> pc=0 immediately, no write on next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcode and funct
// encodings, the ALU operation enum, and the wrap-around address helper
// used by both memories.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [5:0] F_ADD = 6'd32;
   localparam logic [5:0] F_SUB = 6'd34;
   localparam logic [5:0] F_AND = 6'd36;
   localparam logic [5:0] F_OR  = 6'd37;
   localparam logic [5:0] F_SLT = 6'd42;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_e;

   // Byte index of (a + k) inside a memory of 'bytes' bytes. 2^32 is a
   // multiple of any power-of-two size, so 32-bit overflow of a+k is harmless.
   function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                            input logic [1:0]  k,
                                            input int unsigned bytes);
      return (a + {30'd0, k}) % bytes;
   endfunction

endpackage

// File: rtl/mips_test_if.sv
// Data-memory bus between the core and its data memory.
//   addr  : byte address (wrapped by the memory)
//   wdata : store data, little-endian
//   we    : word write strobe, committed on the rising clock edge
//   rdata : combinational load data
interface mips_test_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;

   modport master (output addr, output wdata, output we, input rdata);
   modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/alu.sv
// 32-bit ALU driven by a pre-decoded operation.
//   a_i, b_i : operands
//   op_i     : ADD/SUB wrap without overflow trap, AND, OR, SLT (signed, 1/0)
//   y_o      : result
module alu
   import mips_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_e     op_i,
   output logic [31:0] y_o
);
   always_comb begin
      y_o = '0;
      unique case (op_i)
         ALU_ADD: y_o = a_i + b_i;
         ALU_SUB: y_o = a_i - b_i;
         ALU_AND: y_o = a_i & b_i;
         ALU_OR:  y_o = a_i | b_i;
         ALU_SLT: y_o = {31'd0, $signed(a_i) < $signed(b_i)};
         default: y_o = '0;
      endcase
   end
endmodule

// File: rtl/data_mem.sv
// Data memory: byte array, combinational word read, word write on the
// rising edge. Every byte of an access wraps independently, so unaligned
// and out-of-range addresses just touch 4 consecutive (wrapped) bytes.
//   clk : write clock
//   bus : slave side of the data bus (addr, wdata, we in; rdata out)
module data_mem
   import mips_pkg::*;
#(
   parameter int unsigned DMEM_BYTES = 128
) (
   input  logic        clk,
   mips_test_if.slave  bus
);
   localparam int unsigned AW = $clog2(DMEM_BYTES);

   logic [7:0] mem_array [0:DMEM_BYTES-1];

   always_comb begin
      bus.rdata = '0;
      for (int k = 0; k < 4; k++)
         bus.rdata[8*k +: 8] = mem_array[AW'(wrap_add(bus.addr, 2'(k), DMEM_BYTES))];
   end

   always_ff @(posedge clk) begin
      if (bus.we) begin
         for (int k = 0; k < 4; k++)
            mem_array[AW'(wrap_add(bus.addr, 2'(k), DMEM_BYTES))] <= bus.wdata[8*k +: 8];
      end
   end
endmodule

// File: rtl/instr_mem.sv
// Instruction memory: byte array, combinational little-endian word read.
//   addr_i  : byte address of the word (wraps modulo IMEM_BYTES)
//   instr_o : {mem[a+3], mem[a+2], mem[a+1], mem[a]}
// Contents are loaded from outside through mem_array.
module instr_mem
   import mips_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = 128
) (
   input  logic [31:0] addr_i,
   output logic [31:0] instr_o
);
   localparam int unsigned AW = $clog2(IMEM_BYTES);

   logic [7:0] mem_array [0:IMEM_BYTES-1];

   always_comb begin
      instr_o = '0;
      for (int k = 0; k < 4; k++)
         instr_o[8*k +: 8] = mem_array[AW'(wrap_add(addr_i, 2'(k), IMEM_BYTES))];
   end
endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file, two combinational read ports, one write port.
//   ra1_i/ra2_i, rd1_o/rd2_o : read address / data ($0 always reads 0)
//   we_i, wa_i, wd_i         : write enable / address / data (rising edge)
// Not reset: externally preloaded values must survive reset.
module reg_file (
   input  logic        clk,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);
   logic [31:0] file_array [0:31];

   assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : file_array[ra1_i];
   assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : file_array[ra2_i];

   always_ff @(posedge clk) begin
      if (we_i && (wa_i != 5'd0))
         file_array[wa_i] <= wd_i;
   end
endmodule

// File: rtl/mips_test.sv
// Single-cycle MIPS core (ADD, SUB, AND, OR, SLT, LW, SW, BEQ, J) with its
// own instruction memory, data memory and register file.
//   clk : rising-edge clock; pc, register and memory writes commit together
//   rst : asynchronous active-high; forces pc to 0, blocks all writes,
//         leaves register file and memories untouched
// Top-level nets pc, opcode, funct, rfile_wd are kept for observation.
module mips_test
   import mips_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = 128,
   parameter int unsigned DMEM_BYTES = 128
) (
   input  logic clk,
   input  logic rst
);
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc;
   logic [31:0] instr, pc_plus4, imm_sext;
   logic [31:0] rs_val, rt_val, alu_b, alu_y, rfile_wd;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, wa;
   alu_op_e     alu_op;
   logic        rf_we, dm_we, is_lw;

   mips_test_if dbus ();

   assign pc       = pc_q;
   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign funct    = instr[5:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};
   assign pc_plus4 = pc_q + 32'd4;

   instr_mem #(.IMEM_BYTES(IMEM_BYTES)) InstrMem (
      .addr_i  (pc_q),
      .instr_o (instr)
   );

   // Writes are masked during reset so a reset spanning a clock edge
   // cannot commit the instruction sitting at pc 0.
   reg_file RegFile (
      .clk   (clk),
      .ra1_i (rs),
      .ra2_i (rt),
      .rd1_o (rs_val),
      .rd2_o (rt_val),
      .we_i  (rf_we & ~rst),
      .wa_i  (wa),
      .wd_i  (rfile_wd)
   );

   alu Alu (
      .a_i  (rs_val),
      .b_i  (alu_b),
      .op_i (alu_op),
      .y_o  (alu_y)
   );

   assign dbus.addr  = alu_y;
   assign dbus.wdata = rt_val;
   assign dbus.we    = dm_we & ~rst;

   data_mem #(.DMEM_BYTES(DMEM_BYTES)) DatMem (
      .clk (clk),
      .bus (dbus.slave)
   );

   assign rfile_wd = is_lw ? dbus.rdata : alu_y;

   // Control decode and next-pc selection.
   always_comb begin
      alu_op = ALU_ADD;
      alu_b  = rt_val;
      wa     = rd;
      rf_we  = 1'b0;
      dm_we  = 1'b0;
      is_lw  = 1'b0;
      pc_d   = pc_plus4;
      unique case (opcode)
         OP_RTYPE: begin
            rf_we = 1'b1;
            unique case (funct)
               F_ADD:   alu_op = ALU_ADD;
               F_SUB:   alu_op = ALU_SUB;
               F_AND:   alu_op = ALU_AND;
               F_OR:    alu_op = ALU_OR;
               F_SLT:   alu_op = ALU_SLT;
               default: rf_we  = 1'b0;
            endcase
         end
         OP_LW: begin
            alu_b = imm_sext;
            wa    = rt;
            rf_we = 1'b1;
            is_lw = 1'b1;
         end
         OP_SW: begin
            alu_b = imm_sext;
            dm_we = 1'b1;
         end
         OP_BEQ: begin
            if (rs_val == rt_val)
               pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
         end
         OP_J: pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end
endmodule

// File: tb/tb_mips_test.sv
module tb_mips_test;
   localparam int unsigned IMEM_BYTES = 128;
   localparam int unsigned DMEM_BYTES = 128;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mips_test #(.IMEM_BYTES(IMEM_BYTES), .DMEM_BYTES(DMEM_BYTES)) dut (
      .clk (clk),
      .rst (rst)
   );

   int checks = 0;
   int errors = 0;

   // ISA-level reference state
   logic [31:0] m_reg  [32];
   logic [7:0]  m_imem [128];
   logic [7:0]  m_dmem [128];
   logic [31:0] m_pc;

   typedef struct {
      string       name;
      logic [31:0] instr;
      bit          wd_chk;
      logic [31:0] exp_wd;
      bit          is_mem;
      int          idx;
      logic [31:0] exp_val;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rtype(int rs, int rt, int rd, int f);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(f)};
   endfunction
   function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] jtype(int tgt);
      return {6'd2, 26'(tgt)};
   endfunction

   task automatic put_instr(int a, logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         dut.InstrMem.mem_array[a+k] = w[8*k +: 8];
         m_imem[a+k] = w[8*k +: 8];
      end
   endtask
   task automatic set_reg(int r, logic [31:0] v);
      dut.RegFile.file_array[r] = v;
      m_reg[r] = (r == 0) ? 32'd0 : v;
   endtask
   task automatic set_dmem(int a, logic [7:0] b);
      dut.DatMem.mem_array[a] = b;
      m_dmem[a] = b;
   endtask
   function automatic logic [31:0] dut_reg(int r);
      return dut.RegFile.file_array[r];
   endfunction
   function automatic logic [31:0] dut_dword(int a);
      return {dut.DatMem.mem_array[a+3], dut.DatMem.mem_array[a+2],
              dut.DatMem.mem_array[a+1], dut.DatMem.mem_array[a]};
   endfunction

   // Little-endian word from the model memories with wrap-around.
   function automatic logic [31:0] m_word(bit dmem, logic [31:0] a);
      logic [31:0] w;
      int idx;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         idx = int'((a + 32'(k)) % 32'd128);
         w[8*k +: 8] = dmem ? m_dmem[idx] : m_imem[idx];
      end
      return w;
   endfunction

   // Execute one instruction on the model; reports the write-data value
   // when the ISA defines it (valid R-type result, LW data, SW address).
   task automatic model_step(output logic [31:0] wd, output bit wd_ok);
      logic [31:0] ins, s, t, imm, npc, a, res;
      int op, f, rs, rt, rd, idx;
      ins = m_word(1'b0, m_pc);
      op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
      rd = int'(ins[15:11]); f = int'(ins[5:0]);
      s = m_reg[rs]; t = m_reg[rt];
      imm = {{16{ins[15]}}, ins[15:0]};
      npc = m_pc + 32'd4;
      wd = '0; wd_ok = 1'b0; res = '0;
      case (op)
         0: begin
            wd_ok = 1'b1;
            case (f)
               32: res = s + t;
               34: res = s - t;
               36: res = s & t;
               37: res = s | t;
               42: res = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
               default: wd_ok = 1'b0;
            endcase
            if (wd_ok) begin
               wd = res;
               if (rd != 0) m_reg[rd] = res;
            end
         end
         35: begin
            a = s + imm; wd = m_word(1'b1, a); wd_ok = 1'b1;
            if (rt != 0) m_reg[rt] = wd;
         end
         43: begin
            a = s + imm; wd = a; wd_ok = 1'b1;
            for (int k = 0; k < 4; k++) begin
               idx = int'((a + 32'(k)) % 32'd128);
               m_dmem[idx] = t[8*k +: 8];
            end
         end
         4: if (s == t) npc = npc + (imm << 2);
         2: npc = {npc[31:28], ins[25:0], 2'b00};
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic check_state(string tag);
      int bad;
      bad = 0;
      for (int r = 1; r < 32; r++) if (dut_reg(r) !== m_reg[r]) bad++;
      for (int i = 0; i < 128; i++) if (dut.DatMem.mem_array[i] !== m_dmem[i]) bad++;
      check(tag, 32'(bad), 32'd0);
   endtask

   task automatic begin_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask
   task automatic end_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] f;
      case ($urandom_range(0, 5))
         0: f = 6'd32; 1: f = 6'd34; 2: f = 6'd36;
         3: f = 6'd37; 4: f = 6'd42; default: f = 6'($urandom);
      endcase
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, f};
         4: return itype(35, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom));
         5: return itype(43, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom));
         6: return itype(4, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 6)) - 3);
         7: return jtype(int'($urandom_range(0, 31)));
         8: return {6'($urandom), 26'($urandom)};
         default: return {6'd0, 5'($urandom), 5'($urandom), 5'd0, 5'd0, f};
      endcase
   endfunction

   initial begin
      logic [31:0] wd;
      bit wd_ok;

      // directed table, executed back to back from pc 0
      vecs.push_back('{"ADD",     rtype(1, 2, 3, 32),  1, 32'd8,        0, 3,  32'd8});
      vecs.push_back('{"SUB",     rtype(1, 2, 6, 34),  1, 32'd2,        0, 6,  32'd2});
      vecs.push_back('{"AND",     rtype(1, 2, 7, 36),  1, 32'd1,        0, 7,  32'd1});
      vecs.push_back('{"OR",      rtype(1, 2, 8, 37),  1, 32'd7,        0, 8,  32'd7});
      vecs.push_back('{"SLT_t",   rtype(2, 1, 4, 42),  1, 32'd1,        0, 4,  32'd1});
      vecs.push_back('{"SLT_f",   rtype(1, 2, 9, 42),  1, 32'd0,        0, 9,  32'd0});
      vecs.push_back('{"LW",      itype(35, 0, 5, 0),  1, 32'h12345678, 0, 5,  32'h12345678});
      vecs.push_back('{"SW",      itype(43, 0, 5, 4),  1, 32'd4,        1, 4,  32'h12345678});
      vecs.push_back('{"ADD_r0",  rtype(1, 1, 0, 32),  1, 32'd10,       0, 0,  32'd0});
      vecs.push_back('{"LW_wrap", itype(35, 0, 10, 128), 1, 32'h12345678, 0, 10, 32'h12345678});
      vecs.push_back('{"SUB_neg", rtype(2, 1, 11, 34), 1, 32'hFFFFFFFE, 0, 11, 32'hFFFFFFFE});
      vecs.push_back('{"SLT_sgn", rtype(11, 1, 12, 42), 1, 32'd1,       0, 12, 32'd1});
      vecs.push_back('{"BADFN",   rtype(1, 2, 13, 0),  0, 32'd0,        0, 13, 32'h0000BEEF});
      vecs.push_back('{"BADOP",   itype(63, 1, 14, 0), 0, 32'd0,        0, 14, 32'h00001234});

      for (int i = 0; i < 128; i++) begin
         dut.InstrMem.mem_array[i] = 8'h00; m_imem[i] = 8'h00;
         set_dmem(i, 8'h00);
      end
      for (int r = 0; r < 32; r++) set_reg(r, 32'd0);
      set_reg(1, 32'd5); set_reg(2, 32'd3);
      set_reg(9, 32'hDEAD); set_reg(13, 32'hBEEF); set_reg(14, 32'h1234);
      set_dmem(0, 8'h78); set_dmem(1, 8'h56); set_dmem(2, 8'h34); set_dmem(3, 8'h12);
      for (int i = 0; i < vecs.size(); i++) put_instr(4*i, vecs[i].instr);

      // reset held 10ns across a clock edge
      #1 rst = 1'b1;
      #1 check("reset pc", dut.pc, 32'd0);
      #6 check("reset pc held", dut.pc, 32'd0);
      check("no write in reset", dut_reg(3), 32'd0);
      #3 rst = 1'b0;
      #1;
      check("preload r1", dut_reg(1), 32'd5);
      check("preload r2", dut_reg(2), 32'd3);
      check("preload dmem", dut_dword(0), 32'h12345678);

      for (int i = 0; i < vecs.size(); i++) begin
         check({vecs[i].name, " pc"}, dut.pc, 32'(4*i));
         if (vecs[i].wd_chk) check({vecs[i].name, " wd"}, dut.rfile_wd, vecs[i].exp_wd);
         step();
         if (vecs[i].is_mem)
            check({vecs[i].name, " mem"}, dut_dword(vecs[i].idx), vecs[i].exp_val);
         else
            check({vecs[i].name, " reg"}, dut_reg(vecs[i].idx), vecs[i].exp_val);
      end
      check("table end pc", dut.pc, 32'(4*vecs.size()));

      // BEQ taken at pc 8, then jumps 0x14 -> 0x1C -> 0x40
      begin_reset();
      put_instr(0, rtype(1, 1, 20, 32));
      put_instr(4, rtype(1, 1, 20, 32));
      put_instr(8, itype(4, 1, 2, 2));
      put_instr(20, jtype(7));
      put_instr(28, jtype(32'h10));
      set_reg(2, 32'd5);
      end_reset();
      step(); step();
      check("beq at pc", dut.pc, 32'd8);
      step(); check("beq taken", dut.pc, 32'd20);
      step(); check("j to 1c", dut.pc, 32'h1C);
      step(); check("j to 40", dut.pc, 32'h40);

      // BEQ not taken
      begin_reset();
      set_reg(2, 32'd3);
      end_reset();
      step(); step(); step();
      check("beq not taken", dut.pc, 32'd12);

      // async reset asserted between edges at pc 0x24
      begin_reset();
      put_instr(0, rtype(23, 23, 22, 32));
      put_instr(4, jtype(9));
      put_instr(36, rtype(23, 23, 24, 32));
      set_reg(23, 32'd7); set_reg(22, 32'd0); set_reg(24, 32'd0);
      end_reset();
      step(); check("pre-reset add", dut_reg(22), 32'd14);
      step(); check("reach 0x24", dut.pc, 32'h24);
      @(negedge clk);
      rst = 1'b1;
      #1 check("async reset pc", dut.pc, 32'd0);
      set_reg(22, 32'd0);
      step();
      check("reset blocks write", dut_reg(22), 32'd0);
      check("0x24 not executed", dut_reg(24), 32'd0);
      check("pc held in reset", dut.pc, 32'd0);

      // random programs against the ISA model
      for (int prog = 0; prog < 2; prog++) begin
         if (!rst) begin_reset();
         for (int w = 0; w < 32; w++) put_instr(4*w, rand_instr());
         for (int i = 0; i < 128; i++) set_dmem(i, 8'($urandom));
         set_reg(0, 32'd0);
         for (int r = 1; r < 32; r++)
            set_reg(r, (r <= 3 || $urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1)) : $urandom);
         m_pc = 32'd0;
         end_reset();
         for (int c = 0; c < 250; c++) begin
            check("rand pc", dut.pc, m_pc);
            model_step(wd, wd_ok);
            if (wd_ok) check("rand wd", dut.rfile_wd, wd);
            step();
            check_state("rand state");
         end
         begin_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
